// File: rtl/game_history_if.sv
// Command/status bundle for the game_history undo/redo store.
interface game_history_if #(
  parameter int W     = 134,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [W-1:0]  state_init;
  logic [W-1:0]  state_new;
  logic [W-1:0]  game_state;
  logic [CW-1:0] undo_cnt;
  logic [CW-1:0] redo_cnt;
  logic          ack;
  logic          err;

  modport master (
    output cmd_valid, cmd_op, state_init, state_new,
    input  game_state, undo_cnt, redo_cnt, ack, err
  );

  modport slave (
    input  cmd_valid, cmd_op, state_init, state_new,
    output game_state, undo_cnt, redo_cnt, ack, err
  );
endinterface

// File: rtl/game_history.sv
// Ring-buffer move history with INIT/PUSH/UNDO/REDO commands, one-cycle latency.
// Redo support is built only when GAME_HISTORY_REDO_EN is defined.
module game_history #(
  parameter int W     = 134,
  parameter int DEPTH = 3
) (
  input logic           clk,
  input logic           rst_n,
  game_history_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH);
  localparam logic [1:0] OP_INIT = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_UNDO = 2'b10;
  localparam logic [1:0] OP_REDO = 2'b11;

  logic [W-1:0]  mem [0:DEPTH];
  logic [CW-1:0] head, head_nxt, head_inc, head_dec;
  logic [CW-1:0] undo_q, undo_nxt;
  logic [W-1:0]  state_q, state_nxt, slot_inc, slot_dec;
  logic          zero_base, zero_base_nxt;
  logic          ack_q, ack_nxt, err_q, err_nxt;
  logic          wr_en;
  logic [CW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
`ifdef GAME_HISTORY_REDO_EN
  logic [CW-1:0] redo_q, redo_nxt;
`endif

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == LAST) ? '0 : p + CW'(1);
  endfunction

  function automatic logic [CW-1:0] ptr_dec(input logic [CW-1:0] p);
    return (p == '0) ? LAST : p - CW'(1);
  endfunction

  assign head_inc = ptr_inc(head);
  assign head_dec = ptr_dec(head);

  // Slot 0 reads as zero after reset until something is written there, so a
  // PUSH without INIT can be undone back to the all-zero reset state.
  assign slot_inc = (zero_base && head_inc == '0) ? '0 : mem[head_inc];
  assign slot_dec = (zero_base && head_dec == '0) ? '0 : mem[head_dec];

  always_comb begin
    head_nxt      = head;
    undo_nxt      = undo_q;
    state_nxt     = state_q;
    zero_base_nxt = zero_base;
    ack_nxt       = 1'b0;
    err_nxt       = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = head_inc;
    wr_data       = bus.state_new;
`ifdef GAME_HISTORY_REDO_EN
    redo_nxt      = redo_q;
`endif
    if (bus.cmd_valid) begin
      case (bus.cmd_op)
        OP_INIT: begin
          head_nxt      = '0;
          undo_nxt      = '0;
          state_nxt     = bus.state_init;
          zero_base_nxt = 1'b0;
          wr_en         = 1'b1;
          wr_idx        = '0;
          wr_data       = bus.state_init;
          ack_nxt       = 1'b1;
`ifdef GAME_HISTORY_REDO_EN
          redo_nxt      = '0;
`endif
        end
        OP_PUSH: begin
          head_nxt  = head_inc;
          undo_nxt  = (undo_q == LAST) ? LAST : undo_q + CW'(1);
          state_nxt = bus.state_new;
          wr_en     = 1'b1;
          ack_nxt   = 1'b1;
          if (head_inc == '0) zero_base_nxt = 1'b0;
`ifdef GAME_HISTORY_REDO_EN
          redo_nxt  = '0;
`endif
        end
        OP_UNDO: begin
          if (undo_q != '0) begin
            head_nxt  = head_dec;
            undo_nxt  = undo_q - CW'(1);
            state_nxt = slot_dec;
            ack_nxt   = 1'b1;
`ifdef GAME_HISTORY_REDO_EN
            redo_nxt  = redo_q + CW'(1);
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_REDO: begin
`ifdef GAME_HISTORY_REDO_EN
          if (redo_q != '0) begin
            head_nxt  = head_inc;
            redo_nxt  = redo_q - CW'(1);
            undo_nxt  = undo_q + CW'(1);
            state_nxt = slot_inc;
            ack_nxt   = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
`else
          err_nxt = 1'b1;
`endif
        end
        default: err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      undo_q    <= '0;
      state_q   <= '0;
      zero_base <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef GAME_HISTORY_REDO_EN
      redo_q    <= '0;
`endif
    end else begin
      head      <= head_nxt;
      undo_q    <= undo_nxt;
      state_q   <= state_nxt;
      zero_base <= zero_base_nxt;
      ack_q     <= ack_nxt;
      err_q     <= err_nxt;
`ifdef GAME_HISTORY_REDO_EN
      redo_q    <= redo_nxt;
`endif
    end
  end

  // Ring storage is deliberately unreset; a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) mem[wr_idx] <= wr_data;
  end

  assign bus.game_state = state_q;
  assign bus.undo_cnt   = undo_q;
  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
`ifdef GAME_HISTORY_REDO_EN
  assign bus.redo_cnt   = redo_q;
`else
  assign bus.redo_cnt   = '0;
`endif
endmodule

// File: tb/tb_game_history.sv
// Scoreboard bench for game_history: a reference model pushes expected outputs per cycle.
module tb_game_history;
  localparam int W     = 134;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = W + 2 * CW + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  game_history_if #(.W(W), .DEPTH(DEPTH)) bus ();
  game_history #(.W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  logic [W-1:0] m_mem [0:DEPTH];
  int           m_head, m_undo, m_redo;
  logic [W-1:0] m_state;

  function automatic logic [OW-1:0] pack(input logic [W-1:0] s, input int u, input int r,
                                         input logic a, input logic e);
    return {s, CW'(u), CW'(r), a, e};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.game_state, bus.undo_cnt, bus.redo_cnt, bus.ack, bus.err};
  endfunction

  function automatic logic [W-1:0] rnd_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= DEPTH; i++) m_mem[i] = '0;
    m_head = 0; m_undo = 0; m_redo = 0; m_state = '0;
  endtask

  // code 0..3 = command op, 4 = idle cycle
  task automatic drive(input int code, input logic [W-1:0] d);
    logic a, e;
    a = 1'b0; e = 1'b0;
    bus.cmd_valid  = (code < 4);
    bus.cmd_op     = 2'(code);
    bus.state_init = d;
    bus.state_new  = d;
    case (code)
      0: begin
        m_mem[0] = d; m_head = 0; m_undo = 0; m_redo = 0; m_state = d; a = 1'b1;
      end
      1: begin
        m_head = (m_head + 1) % (DEPTH + 1);
        m_mem[m_head] = d; m_state = d;
        m_undo = (m_undo < DEPTH) ? m_undo + 1 : DEPTH;
        m_redo = 0; a = 1'b1;
      end
      2: begin
        if (m_undo > 0) begin
          m_head = (m_head + DEPTH) % (DEPTH + 1);
          m_state = m_mem[m_head];
          m_undo--;
`ifdef GAME_HISTORY_REDO_EN
          m_redo++;
`endif
          a = 1'b1;
        end else e = 1'b1;
      end
      3: begin
`ifdef GAME_HISTORY_REDO_EN
        if (m_redo > 0) begin
          m_head = (m_head + 1) % (DEPTH + 1);
          m_state = m_mem[m_head];
          m_redo--; m_undo++; a = 1'b1;
        end else e = 1'b1;
`else
        e = 1'b1;
`endif
      end
      default: ;
    endcase
    exp_q.push_back(pack(m_state, m_undo, m_redo, a, e));
  endtask

  task automatic test_reset();
    logic [OW-1:0] expv;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.state_init = '0; bus.state_new = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    expv = pack('0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv) begin
      errors++; $display("FAIL reset_async: got %h expected %h", obs(), expv);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (obs() !== expv) begin
      errors++; $display("FAIL reset_held: got %h expected %h", obs(), expv);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_init();
    logic [OW-1:0] expv;
    int ops[3] = '{0, 4, 4};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], W'(8'hA5));
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL init step %0d: got %h expected %h", i, obs(), expv);
      end
    end
    checks++;
    if (bus.game_state !== W'(8'hA5)) begin
      errors++; $display("FAIL init_value: got %h expected a5", bus.game_state);
    end
  endtask

  task automatic test_overflow();
    logic [OW-1:0] expv;
    int ops[11] = '{0, 1, 1, 1, 1, 1, 2, 2, 2, 2, 4};
    for (int i = 0; i < 11; i++) begin
      drive(ops[i], W'(16'h5000 + i));
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL overflow step %0d: got %h expected %h", i, obs(), expv);
      end
    end
    checks++;
    if (bus.game_state !== W'(16'h5002)) begin
      errors++; $display("FAIL overflow_floor: got %h expected 5002", bus.game_state);
    end
  endtask

  task automatic test_redo();
    logic [OW-1:0] expv;
    int ops[9] = '{0, 1, 1, 2, 2, 3, 1, 3, 4};
    logic [W-1:0] dat[9];
    for (int i = 0; i < 9; i++) dat[i] = W'(16'h6000 + i);
    dat[6] = W'(16'h6009);
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], dat[i]);
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL redo step %0d: got %h expected %h", i, obs(), expv);
      end
    end
  endtask

  task automatic test_wrap();
    logic [OW-1:0] expv;
    logic [W-1:0] pushed[7];
    for (int i = 0; i < 7; i++) pushed[i] = rnd_state();
    drive(0, rnd_state());
    @(posedge clk); #1;
    expv = exp_q.pop_front();
    checks++;
    if (obs() !== expv) begin
      errors++; $display("FAIL wrap_init: got %h expected %h", obs(), expv);
    end
    for (int i = 0; i < 10; i++) begin
      drive((i < 7) ? 1 : 2, (i < 7) ? pushed[i] : '0);
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL wrap step %0d: got %h expected %h", i, obs(), expv);
      end
    end
    checks++;
    if (bus.game_state !== pushed[3]) begin
      errors++; $display("FAIL wrap_value: got %h expected %h", bus.game_state, pushed[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] expv;
    int ops[5] = '{2, 1, 2, 4, 2};
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.state_new = W'(16'h7777);
    #2 rst_n = 1'b0;
    #1;
    expv = pack('0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs() !== expv) begin
      errors++; $display("FAIL reset_mid_async: got %h expected %h", obs(), expv);
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== expv) begin
      errors++; $display("FAIL reset_mid_edge: got %h expected %h", obs(), expv);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], W'(16'h7100 + i));
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL reset_mid step %0d: got %h expected %h", i, obs(), expv);
      end
    end
  endtask

  task automatic test_no_redo();
    logic [OW-1:0] expv;
    int ops[5] = '{0, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], W'(16'h8000 + i));
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL no_redo step %0d: got %h expected %h", i, obs(), expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] expv;
    int code;
    for (int i = 0; i < 200; i++) begin
      code = (i == 0) ? 0 : int'($urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) code = 0;
      drive(code, rnd_state());
      @(posedge clk); #1;
      expv = exp_q.pop_front();
      checks++;
      if (obs() !== expv) begin
        errors++; $display("FAIL random step %0d: got %h expected %h", i, obs(), expv);
      end
      checks++;
      if ((bus.ack && bus.err) || (int'(bus.undo_cnt) + int'(bus.redo_cnt) > DEPTH)) begin
        errors++;
        $display("FAIL random_invariant step %0d: got ack=%b err=%b undo=%0d redo=%0d, required exclusive pulses and sum<=%0d",
                 i, bus.ack, bus.err, bus.undo_cnt, bus.redo_cnt, DEPTH);
      end
    end
    drive(4, '0);
    @(posedge clk); #1;
    expv = exp_q.pop_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_overflow();
    test_redo();
    test_wrap();
    test_reset_mid();
    test_no_redo();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_history.md
GAME_HISTORY -- requirements
Module: game_history

Interface
REQ-001 Parameter W, default 134: game-state vector width in bits; legal 1..256.
REQ-002 Parameter DEPTH, default 3: maximum number of retractable moves; legal 1..15.
REQ-003 Localparam CW = clog2(DEPTH+1): width of the counters and the pointer. The ring holds DEPTH+1 slots.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 cmd_valid  in  1: command strobe; always accepted, so there is no ready signal.
REQ-007 cmd_op  in  2: command code. 00 INIT, 01 PUSH, 10 UNDO, 11 REDO.
REQ-008 state_init  in  W: level start state, sampled on INIT.
REQ-009 state_new  in  W: post-move state from the box-move or man-move logic, sampled on PUSH.
REQ-010 game_state  out  W: registered current state.
REQ-011 undo_cnt  out  CW: number of UNDOs currently available.
REQ-012 redo_cnt  out  CW: number of REDOs currently available.
REQ-013 ack  out  1: one-cycle pulse, the cycle after an accepted command.
REQ-014 err  out  1: one-cycle pulse, the cycle after a rejected command; state is unchanged.

Function
REQ-015 Storage: a ring mem[0..DEPTH] of W-bit entries plus a head pointer; game_state always equals mem[head] registered.
REQ-016 Commands take effect only when cmd_valid=1; with cmd_valid=0 all state holds and ack=err=0.
REQ-017 INIT:
- mem[0] <= state_init; head <= 0; undo_cnt <= 0; redo_cnt <= 0.
- game_state <= state_init; ack pulses.
REQ-018 PUSH:
- head <= head+1 mod (DEPTH+1); mem[new head] <= state_new; game_state <= state_new.
- undo_cnt <= min(undo_cnt+1, DEPTH); redo_cnt <= 0; ack pulses.
REQ-019 PUSH when undo_cnt=DEPTH overwrites the oldest entry; undo_cnt stays at DEPTH.
REQ-020 UNDO with undo_cnt>0:
- head <= head-1 mod (DEPTH+1); game_state <= mem[head-1].
- undo_cnt decrements; redo_cnt increments; ack pulses.
REQ-021 UNDO with undo_cnt=0: rejected; err pulses; all state holds.
REQ-022 REDO with redo_cnt>0:
- head <= head+1 mod (DEPTH+1); game_state <= mem[head+1].
- redo_cnt decrements; undo_cnt increments; ack pulses.
REQ-023 REDO with redo_cnt=0: rejected; err pulses.
REQ-024 Invariant: undo_cnt+redo_cnt <= DEPTH at all times.
REQ-025 Latency: game_state, the counters, ack and err all update on the first rising edge after the command cycle, one cycle total.
REQ-026 Back-to-back commands on consecutive cycles are legal; each sees the state left by the previous one.
REQ-027 ack and err are never both high in the same cycle.
REQ-028 Pointer wrap: increment from DEPTH goes to 0; decrement from 0 goes to DEPTH.

Reset
REQ-029 While rst_n=0, regardless of clk:
- head=0; undo_cnt=0; redo_cnt=0; ack=0; err=0; game_state=0.
REQ-030 Ring contents are not reset; the counters guarantee that stale slots are never selected.
REQ-031 Reset asserted mid-command aborts the command; the first command after release is handled as in REQ-016..REQ-023.
REQ-032 After reset, a PUSH without a prior INIT is legal; it leaves undo_cnt=1, and an UNDO then returns game_state=0.

Configuration
REQ-033 Macro GAME_HISTORY_REDO_EN selects whether redo is built.
REQ-034 With GAME_HISTORY_REDO_EN defined: behaviour as in REQ-022..REQ-023.
REQ-035 With GAME_HISTORY_REDO_EN undefined:
- redo_cnt tied to 0; the redo counter logic is not built.
- Every REDO is rejected with err.
- UNDO does not increment any redo count.
- All other behaviour is unchanged.

Verification
REQ-036 Reset, then INIT state_init=0xA5 -> game_state=0xA5, undo_cnt=0, redo_cnt=0, ack=1 for one cycle.
REQ-037 DEPTH=3: INIT S0, PUSH S1..S5 -> undo_cnt=3. Three UNDOs -> game_state S4, S3, S2. Fourth UNDO -> err=1, game_state stays S2.
REQ-038 INIT S0, PUSH S1, PUSH S2, UNDO, UNDO -> S0, redo_cnt=2. REDO -> S1. PUSH S9 -> S9, redo_cnt=0. REDO -> err=1.
REQ-039 Wrap: DEPTH=3, 7 PUSHes then 3 UNDOs on consecutive cycles -> the pointer passes 0 -> DEPTH correctly; game_state equals the 4th pushed value.
REQ-040 Assert rst_n=0 in the same cycle as a PUSH -> game_state=0 and counters 0 immediately, without waiting for a clock edge; no ack. Then UNDO -> err=1.
REQ-041 Build with GAME_HISTORY_REDO_EN undefined: INIT, PUSH, UNDO, REDO -> REDO gives err=1, redo_cnt=0 throughout, game_state stays the INIT value.
